inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage directly downstream of the program counter register in the multi-cycle CPU.
//  Takes the current PC and runs one instruction-memory read per fetch with a req/ack handshake.
//  Holds the returned word in the instruction register (IR) until decode accepts it.
//  On acceptance, pulses pc_wre and presents pc+4 so the PC register advances.
// PARAMETERS
//  TIMEOUT   16            max cycles in REQ waiting for mem_ack before a fetch error (>=1)
//  IR_RESET  32'h0000_0000 IR value after reset and after an error (NOP)
// PORTS
//  clk        in   1   system clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  pc         in   32  current PC (output of the PC register)
//  fetch_en   in   1   control unit requests a fetch; sampled only in IDLE
//  mem_req    out  1   instruction-memory read request
//  mem_addr   out  32  word address of the read (latched PC)
//  mem_rdata  in   32  read data; valid only in the cycle mem_ack=1
//  mem_ack    in   1   memory completes the read
//  ir_out     out  32  instruction register contents
//  ir_valid   out  1   ir_out holds an unconsumed instruction
//  ir_ready   in   1   decode accepts ir_out
//  pc_plus4   out  32  latched fetch address + 4; drives NPC on a sequential step
//  pc_wre     out  1   one-cycle pulse; write enable to the PC register
//  fetch_err  out  1   one-cycle pulse on misaligned PC or timeout
//  busy       out  1   high in any state other than IDLE
//  instr_cnt  out  32  count of instructions accepted by decode; wraps at 2^32
// BEHAVIOUR
//  Reset (async, any state):
//   - state goes to IDLE; ir_out = IR_RESET.
//   - mem_addr, pc_plus4 and instr_cnt go to 0.
//   - mem_req, ir_valid, pc_wre, fetch_err and busy go low.
//   - timeout counter clears.
//   - A transfer in flight is abandoned. Any mem_ack arriving after reset is ignored.
//  FSM states: IDLE, REQ, HOLD. All outputs are registered.
//  IDLE:
//   - fetch_en=1 with pc[1:0]!=0: fetch_err=1 for the next cycle; stay in IDLE; IR unchanged.
//   - fetch_en=1 with pc aligned: mem_addr<=pc, pc_plus4<=pc+4 (mod 2^32), counter<=0,
//     mem_req<=1, go to REQ.
//  REQ:
//   - mem_req stays high; mem_addr is stable.
//   - mem_ack=1: ir_out<=mem_rdata, mem_req<=0, ir_valid<=1, go to HOLD.
//     Minimum latency from fetch_en to ir_valid is 2 cycles.
//   - mem_ack=0: counter increments. When the counter reaches TIMEOUT-1 with no ack:
//     mem_req<=0, fetch_err pulses 1 cycle, ir_out<=IR_RESET, go to IDLE.
//   - If ack and timeout coincide in the same cycle, ack wins.
//  HOLD:
//   - ir_valid=1; ir_out is stable until transfer.
//   - ir_ready=1 transfers in that cycle: ir_valid<=0, pc_wre pulses 1 cycle,
//     instr_cnt<=instr_cnt+1, go to IDLE.
//   - ir_ready=0: stay in HOLD indefinitely (no timeout).
//  Other rules:
//   - fetch_en outside IDLE is ignored, never queued.
//     Back-to-back fetches therefore take at least 3 cycles each.
//   - mem_ack outside REQ is ignored; mem_rdata is sampled only on ack in REQ.
//   - pc_wre and fetch_err are never high in the same cycle.
//   - busy = (state != IDLE).
// TESTING
//  1. Reset mid-REQ (assert rst while mem_req=1)
//     -> mem_req=0, busy=0 immediately; a later mem_ack leaves ir_out at 0.
//  2. pc=0x0000_0010, fetch_en=1, ack on 1st REQ cycle with rdata=0x2002_0005, ir_ready=1
//     -> mem_addr=0x10, ir_out=0x2002_0005, pc_plus4=0x14, one pc_wre pulse, instr_cnt=1.
//  3. ack after 5 wait cycles, ir_ready held low 4 cycles
//     -> mem_req high exactly 6 cycles; ir_valid high 4 cycles plus the transfer cycle.
//  4. pc=0x0000_0006, fetch_en=1
//     -> fetch_err pulse, mem_req never asserted, state stays IDLE.
//  5. TIMEOUT=16, no ack ever
//     -> fetch_err after 16 REQ cycles, ir_out=IR_RESET, busy=0 next cycle.
//  6. pc=0xFFFF_FFFC fetch, plus fetch_en pulsed during HOLD
//     -> pc_plus4=0x0000_0000 (wrap); the HOLD fetch_en is ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage between the PC register and decode
//
// Purpose: takes the current PC, runs one instruction-memory read per fetch over a
// req/ack handshake, holds the returned word in the IR until decode accepts it, then
// pulses pc_wre_o with pc_plus4_o so the PC register advances.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   pc_i, fetch_en_i    current PC and fetch request (fetch_en_i sampled only in IDLE)
//   mem_req_o           instruction-memory read request
//   mem_addr_o          latched fetch address
//   mem_rdata_i         read data, taken only on mem_ack_i while requesting
//   mem_ack_i           memory completes the read
//   ir_out_o            instruction register
//   ir_valid_o          ir_out_o holds an unconsumed instruction
//   ir_ready_i          decode accepts ir_out_o
//   pc_plus4_o          latched fetch address + 4
//   pc_wre_o            one-cycle PC write enable on transfer to decode
//   fetch_err_o         one-cycle pulse on misaligned PC or memory timeout
//   busy_o              high whenever not IDLE
//   instr_cnt_o         instructions accepted by decode, wraps at 2^32

module inst_fetch_unit #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        fetch_en_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [31:0] ir_out_o,
   output logic        ir_valid_o,
   input  logic        ir_ready_i,
   output logic [31:0] pc_plus4_o,
   output logic        pc_wre_o,
   output logic        fetch_err_o,
   output logic        busy_o,
   output logic [31:0] instr_cnt_o
);

   // A width of at least one bit keeps TIMEOUT=1 legal.
   localparam int unsigned    CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_req_q, mem_req_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      pc_plus4_q, pc_plus4_d;
   logic [31:0]      ir_q, ir_d;
   logic             ir_valid_q, ir_valid_d;
   logic             pc_wre_q, pc_wre_d;
   logic             fetch_err_q, fetch_err_d;
   logic [31:0]      instr_cnt_q, instr_cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'h0;
         pc_plus4_q  <= 32'h0;
         ir_q        <= IR_RESET;
         ir_valid_q  <= 1'b0;
         pc_wre_q    <= 1'b0;
         fetch_err_q <= 1'b0;
         instr_cnt_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         pc_plus4_q  <= pc_plus4_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         pc_wre_q    <= pc_wre_d;
         fetch_err_q <= fetch_err_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      pc_plus4_d  = pc_plus4_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      instr_cnt_d = instr_cnt_q;
      // Pulses: low unless raised below, so pc_wre and fetch_err can never overlap.
      pc_wre_d    = 1'b0;
      fetch_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fetch_en_i) begin
               if (pc_i[1:0] != 2'b00) begin
                  fetch_err_d = 1'b1;
               end else begin
                  mem_addr_d = pc_i;
                  pc_plus4_d = pc_i + 32'd4;
                  cnt_d      = '0;
                  mem_req_d  = 1'b1;
                  state_d    = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Ack is tested first so it wins over a coinciding timeout.
            if (mem_ack_i) begin
               ir_d       = mem_rdata_i;
               mem_req_d  = 1'b0;
               ir_valid_d = 1'b1;
               state_d    = S_HOLD;
            end else if (cnt_q == CNT_MAX) begin
               mem_req_d   = 1'b0;
               fetch_err_d = 1'b1;
               ir_d        = IR_RESET;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (ir_ready_i) begin
               ir_valid_d  = 1'b0;
               pc_wre_d    = 1'b1;
               instr_cnt_d = instr_cnt_q + 32'd1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign pc_plus4_o  = pc_plus4_q;
   assign ir_out_o    = ir_q;
   assign ir_valid_o  = ir_valid_q;
   assign pc_wre_o    = pc_wre_q;
   assign fetch_err_o = fetch_err_q;
   assign busy_o      = (state_q != S_IDLE);
   assign instr_cnt_o = instr_cnt_q;

endmodule
